// File: rtl/xyolo_vread_pp_pkg.sv
// Shared definitions for the ping-pong vector reader: config register map
// and controller state encoding.
package xyolo_vread_pp_pkg;

    // Config register addresses.
    localparam int unsigned XYOLO_VREAD_CONF_EXT_ADDR = 0;
    localparam int unsigned XYOLO_VREAD_CONF_OFFSET   = 1;
    localparam int unsigned XYOLO_VREAD_CONF_LEN_A    = 2;
    localparam int unsigned XYOLO_VREAD_CONF_INCR_A   = 3;
    localparam int unsigned XYOLO_VREAD_CONF_LEN_B    = 4;
    localparam int unsigned XYOLO_VREAD_CONF_START_B  = 5;
    localparam int unsigned XYOLO_VREAD_CONF_INCR_B   = 6;
    localparam int unsigned XYOLO_VREAD_CONF_BIAS_IDX = 7;

    // Controller states.
    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

endpackage

// File: rtl/xyolo_vread_pp_lane.sv
// One reader lane: strided fetch from the databus into its ping-pong buffer,
// bias capture per bank, and the registered read port feeding the stream.

// Simple dual-port buffer: one write port, one registered read port that
// holds its output while not enabled.
module iob_2p_mem #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              w_en,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    input  logic              r_en,
    input  logic [ADDR_W-1:0] r_addr,
    output logic [DATA_W-1:0] r_data
);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    // Write and registered read; r_data keeps its value while r_en is low.
    // NOTE: the array and read register have no reset so they map onto RAM macros.
    always_ff @(posedge clk) begin
        if (w_en) mem[w_addr] <= w_data;
        if (r_en) r_data <= mem[r_addr];
    end

endmodule

module yolo_vread_lane #(
    parameter int DATA_W     = 32,
    parameter int IO_ADDR_W  = 32,
    parameter int MEM_ADDR_W = 10,
    parameter int LANE       = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    active,
    input  logic [IO_ADDR_W-1:0]    ext_addr,
    input  logic [IO_ADDR_W/2-1:0]  offset,
    input  logic [MEM_ADDR_W-1:0]   len_a,
    input  logic [IO_ADDR_W/2-1:0]  incr_a,
    input  logic [MEM_ADDR_W-2:0]   bias_idx,
    input  logic                    wbank,
    input  logic                    rbank,
    output logic                    databus_valid,
    input  logic                    databus_ready,
    output logic [IO_ADDR_W-1:0]    databus_addr,
    input  logic [DATA_W-1:0]       databus_rdata,
    input  logic                    rd_en,
    input  logic [MEM_ADDR_W-1:0]   rd_addr,
    output logic [DATA_W-1:0]       rd_data,
    output logic [DATA_W-1:0]       bias,
    output logic                    fetch_done
);

    logic [MEM_ADDR_W-1:0] k;
    logic [IO_ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]     bias_q [2];
    logic                  hs;

    assign fetch_done    = (k == len_a);
    assign databus_valid = active && !fetch_done;
    assign hs            = databus_valid && databus_ready;
    assign databus_addr  = addr_q;
    assign bias          = bias_q[rbank];

    // Fetch counter and running address (base + k*incr kept incrementally).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k      <= '0;
            addr_q <= '0;
        end else if (start) begin
            k      <= '0;
            addr_q <= ext_addr + IO_ADDR_W'(LANE) * IO_ADDR_W'(offset);
        end else if (hs) begin
            k      <= k + MEM_ADDR_W'(1);
            addr_q <= addr_q + IO_ADDR_W'(incr_a);
        end
    end

    // Capture the bias word of the bank being filled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bias_q[0] <= '0;
            bias_q[1] <= '0;
        end else if (hs && (k == {1'b0, bias_idx})) begin
            bias_q[wbank] <= databus_rdata;
        end
    end

    iob_2p_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (MEM_ADDR_W)
    ) u_mem (
        .clk    (clk),
        .w_en   (hs),
        .w_addr ({wbank, k[MEM_ADDR_W-2:0]}),
        .w_data (databus_rdata),
        .r_en   (rd_en),
        .r_addr (rd_addr),
        .r_data (rd_data)
    );

endmodule

// File: rtl/xyolo_vread_pp.sv
// Ping-pong vector reader top: config registers, run/idle controller, shared
// stream-address counter with valid/ready output, and NVECT fetch lanes.
// Wide buses carry lane 0 in the MSBs; 1-bit per-lane vectors use bit i.
module xyolo_vread_pp
    import xyolo_vread_pp_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int IO_ADDR_W  = 32,
    parameter int MEM_ADDR_W = 10,
    parameter int NVECT      = 4,
    parameter int CFG_ADDR_W = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clear,
    input  logic                        run,
    output logic                        done,
    output logic                        busy_err,
    input  logic                        valid,
    input  logic [CFG_ADDR_W-1:0]       addr,
    input  logic [IO_ADDR_W-1:0]        wdata,
    input  logic                        wstrb,
    output logic [NVECT-1:0]            databus_valid,
    input  logic [NVECT-1:0]            databus_ready,
    output logic [NVECT*IO_ADDR_W-1:0]  databus_addr,
    input  logic [NVECT*DATA_W-1:0]     databus_rdata,
    output logic                        flow_out_valid,
    input  logic                        flow_out_ready,
    output logic [NVECT*DATA_W-1:0]     flow_out_weight,
    output logic [NVECT*DATA_W-1:0]     flow_out_bias
);

    localparam int OFF_W   = IO_ADDR_W / 2;
    localparam int BANK_AW = MEM_ADDR_W - 1;

    // Programmed configuration.
    logic [IO_ADDR_W-1:0]  cfg_ext_addr;
    logic [OFF_W-1:0]      cfg_offset, cfg_incr_a;
    logic [MEM_ADDR_W-1:0] cfg_len_a, cfg_len_b;
    logic [BANK_AW-1:0]    cfg_start_b, cfg_incr_b, cfg_bias_idx;

    // Configuration frozen at run.
    logic [OFF_W-1:0]      sh_incr_a;
    logic [MEM_ADDR_W-1:0] sh_len_a, sh_len_b;
    logic [BANK_AW-1:0]    sh_incr_b, sh_bias_idx;
    logic                  pp, wbank, rbank;

    state_t                state, state_nxt;
    logic                  start, active;
    logic [NVECT-1:0]      lane_done;
    logic                  fetch_done_all, stream_done;

    logic [MEM_ADDR_W-1:0] rd_cnt, acc_cnt;
    logic [BANK_AW-1:0]    rd_ptr;
    logic                  rd_issue;

    assign active         = (state == S_ACTIVE);
    assign fetch_done_all = &lane_done;
    assign stream_done    = (acc_cnt == sh_len_b);

    // Config register writes; clear wipes them without touching a running job.
    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_ext_addr <= '0;
            cfg_offset   <= '0;
            cfg_len_a    <= '0;
            cfg_incr_a   <= '0;
            cfg_len_b    <= '0;
            cfg_start_b  <= '0;
            cfg_incr_b   <= '0;
            cfg_bias_idx <= '0;
        end else if (clear) begin
            cfg_ext_addr <= '0;
            cfg_offset   <= '0;
            cfg_len_a    <= '0;
            cfg_incr_a   <= '0;
            cfg_len_b    <= '0;
            cfg_start_b  <= '0;
            cfg_incr_b   <= '0;
            cfg_bias_idx <= '0;
        end else if (valid && wstrb) begin
            case (addr)
                CFG_ADDR_W'(XYOLO_VREAD_CONF_EXT_ADDR): cfg_ext_addr <= wdata;
                CFG_ADDR_W'(XYOLO_VREAD_CONF_OFFSET):   cfg_offset   <= wdata[OFF_W-1:0];
                CFG_ADDR_W'(XYOLO_VREAD_CONF_LEN_A):    cfg_len_a    <= wdata[MEM_ADDR_W-1:0];
                CFG_ADDR_W'(XYOLO_VREAD_CONF_INCR_A):   cfg_incr_a   <= wdata[OFF_W-1:0];
                CFG_ADDR_W'(XYOLO_VREAD_CONF_LEN_B):    cfg_len_b    <= wdata[MEM_ADDR_W-1:0];
                CFG_ADDR_W'(XYOLO_VREAD_CONF_START_B):  cfg_start_b  <= wdata[BANK_AW-1:0];
                CFG_ADDR_W'(XYOLO_VREAD_CONF_INCR_B):   cfg_incr_b   <= wdata[BANK_AW-1:0];
                CFG_ADDR_W'(XYOLO_VREAD_CONF_BIAS_IDX): cfg_bias_idx <= wdata[BANK_AW-1:0];
                default: ;
            endcase
        end
    end

    // Freeze configuration and pick banks at run; pp flips only if a fetch happens.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_incr_a   <= '0;
            sh_len_a    <= '0;
            sh_len_b    <= '0;
            sh_incr_b   <= '0;
            sh_bias_idx <= '0;
            pp          <= 1'b0;
            wbank       <= 1'b0;
            rbank       <= 1'b0;
        end else if (start) begin
            sh_incr_a   <= cfg_incr_a;
            sh_len_a    <= cfg_len_a;
            sh_len_b    <= cfg_len_b;
            sh_incr_b   <= cfg_incr_b;
            sh_bias_idx <= cfg_bias_idx;
            wbank       <= pp;
            rbank       <= ~pp;
            if (cfg_len_a != '0) pp <= ~pp;
        end
    end

    // Controller state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    // Next state, start strobe and done flag.
    // NOTE: defaults first so no path through the block leaves a latch behind.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                done = 1'b1;
                if (run) begin
                    start     = 1'b1;
                    state_nxt = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (fetch_done_all && stream_done) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Sticky error for a run that arrives while a job is still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              busy_err <= 1'b0;
        else if (clear)          busy_err <= 1'b0;
        else if (run && active)  busy_err <= 1'b1;
    end

    // A read issues when words remain and the output slot is free or draining.
    assign rd_issue = active && (rd_cnt < sh_len_b) && (!flow_out_valid || flow_out_ready);

    // Stream address walk (wraps inside the bank), output valid and accept count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt         <= '0;
            rd_ptr         <= '0;
            acc_cnt        <= '0;
            flow_out_valid <= 1'b0;
        end else if (start) begin
            rd_cnt         <= '0;
            rd_ptr         <= cfg_start_b;
            acc_cnt        <= '0;
            flow_out_valid <= 1'b0;
        end else begin
            if (rd_issue) begin
                rd_cnt <= rd_cnt + MEM_ADDR_W'(1);
                rd_ptr <= rd_ptr + sh_incr_b;
            end
            if (flow_out_valid && flow_out_ready) acc_cnt <= acc_cnt + MEM_ADDR_W'(1);
            flow_out_valid <= rd_issue || (flow_out_valid && !flow_out_ready);
        end
    end

    for (genvar i = 0; i < NVECT; i++) begin : g_lane
        localparam int S = NVECT - 1 - i;

        yolo_vread_lane #(
            .DATA_W     (DATA_W),
            .IO_ADDR_W  (IO_ADDR_W),
            .MEM_ADDR_W (MEM_ADDR_W),
            .LANE       (i)
        ) u_lane (
            .clk           (clk),
            .rst_n         (rst_n),
            .start         (start),
            .active        (active),
            .ext_addr      (cfg_ext_addr),
            .offset        (cfg_offset),
            .len_a         (sh_len_a),
            .incr_a        (sh_incr_a),
            .bias_idx      (sh_bias_idx),
            .wbank         (wbank),
            .rbank         (rbank),
            .databus_valid (databus_valid[i]),
            .databus_ready (databus_ready[i]),
            .databus_addr  (databus_addr[S*IO_ADDR_W +: IO_ADDR_W]),
            .databus_rdata (databus_rdata[S*DATA_W +: DATA_W]),
            .rd_en         (rd_issue),
            .rd_addr       ({rbank, rd_ptr}),
            .rd_data       (flow_out_weight[S*DATA_W +: DATA_W]),
            .bias          (flow_out_bias[S*DATA_W +: DATA_W]),
            .fetch_done    (lane_done[i])
        );
    end

endmodule

// File: tb/tb_xyolo_vread_pp.sv
// Directed bench for xyolo_vread_pp: fetch addressing, ping-pong streaming,
// bias selection, backpressure, random databus ready, busy error and reset.
module tb_xyolo_vread_pp;

    localparam int DATA_W     = 32;
    localparam int IO_ADDR_W  = 32;
    localparam int MEM_ADDR_W = 10;
    localparam int NVECT      = 4;
    localparam int CFG_ADDR_W = 4;
    localparam int BANK_WORDS = 512;
    localparam int WW         = NVECT * DATA_W;

    logic                       clk, rst_n, clear, run, done, busy_err;
    logic                       valid, wstrb;
    logic [CFG_ADDR_W-1:0]      addr;
    logic [IO_ADDR_W-1:0]       wdata;
    logic [NVECT-1:0]           databus_valid, databus_ready;
    logic [NVECT*IO_ADDR_W-1:0] databus_addr;
    logic [NVECT*DATA_W-1:0]    databus_rdata;
    logic                       flow_out_valid, flow_out_ready;
    logic [WW-1:0]              flow_out_weight, flow_out_bias;

    xyolo_vread_pp #(
        .DATA_W (DATA_W), .IO_ADDR_W (IO_ADDR_W), .MEM_ADDR_W (MEM_ADDR_W),
        .NVECT (NVECT), .CFG_ADDR_W (CFG_ADDR_W)
    ) dut (
        .clk (clk), .rst_n (rst_n), .clear (clear), .run (run), .done (done),
        .busy_err (busy_err), .valid (valid), .addr (addr), .wdata (wdata),
        .wstrb (wstrb), .databus_valid (databus_valid), .databus_ready (databus_ready),
        .databus_addr (databus_addr), .databus_rdata (databus_rdata),
        .flow_out_valid (flow_out_valid), .flow_out_ready (flow_out_ready),
        .flow_out_weight (flow_out_weight), .flow_out_bias (flow_out_bias)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External memory: each word encodes its lane and address.
    function automatic logic [31:0] data_of(input int lane, input logic [31:0] a);
        return {4'hA, 4'(lane), a[23:0]};
    endfunction

    for (genvar g = 0; g < NVECT; g++) begin : g_mem
        assign databus_rdata[(NVECT-1-g)*DATA_W +: DATA_W] =
            data_of(g, databus_addr[(NVECT-1-g)*IO_ADDR_W +: IO_ADDR_W]);
    end

    // Reference model state.
    logic [31:0] m_ext, m_off, m_len_a, m_incr_a, m_len_b, m_start_b, m_incr_b, m_bias_idx;
    logic [31:0] bank_m [2][NVECT][BANK_WORDS];
    logic [31:0] bias_m [2][NVECT];
    int          pp_m;
    int          n_checks, n_errors;
    int          dc, ff;

    task automatic check(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cfg_wr(input int a, input logic [31:0] d);
        valid = 1'b1; wstrb = 1'b1; addr = CFG_ADDR_W'(a); wdata = d;
        @(posedge clk); #1;
        valid = 1'b0; wstrb = 1'b0;
    endtask

    task automatic set_cfg(input logic [31:0] ext, off, len_a, incr_a, len_b, start_b, incr_b, bidx);
        cfg_wr(0, ext);    cfg_wr(1, off);     cfg_wr(2, len_a);  cfg_wr(3, incr_a);
        cfg_wr(4, len_b);  cfg_wr(5, start_b); cfg_wr(6, incr_b); cfg_wr(7, bidx);
        m_ext = ext; m_off = off; m_len_a = len_a; m_incr_a = incr_a;
        m_len_b = len_b; m_start_b = start_b; m_incr_b = incr_b; m_bias_idx = bidx;
    endtask

    // Run one job, checking every fetch and stream beat against the model.
    task automatic do_op(input bit rnd, input int stall_at, input int stall_len,
                         input int busy_at, output int done_cyc, output int first_fv);
        int k [NVECT];
        int acc, c, last_ev, wb, rb, idx;
        logic [31:0] ea;
        logic [WW-1:0] exp_w, exp_b;
        wb = pp_m; rb = 1 - pp_m;
        if (m_len_a != 0) pp_m = 1 - pp_m;
        foreach (k[i]) k[i] = 0;
        acc = 0; last_ev = 0; first_fv = 0;
        run = 1'b1; @(posedge clk); #1; run = 1'b0; c = 1;
        check("done_fall", done, 1'b0);
        while (!done && c < 4000) begin
            for (int i = 0; i < NVECT; i++)
                databus_ready[i] = rnd ? ($urandom_range(0, 2) == 0) : 1'b1;
            flow_out_ready = !(c >= stall_at && c < stall_at + stall_len);
            run = (c == busy_at);
            #1;
            for (int i = 0; i < NVECT; i++) begin
                check($sformatf("dbv%0d", i), databus_valid[i], k[i] < m_len_a);
                if (databus_valid[i]) begin
                    ea = m_ext + i * m_off + k[i] * m_incr_a;
                    check($sformatf("addr%0d_%0d", i, k[i]),
                          databus_addr[(NVECT-1-i)*IO_ADDR_W +: IO_ADDR_W], ea);
                    if (databus_ready[i]) begin
                        bank_m[wb][i][k[i] % BANK_WORDS] = data_of(i, ea);
                        if (k[i] == m_bias_idx) bias_m[wb][i] = data_of(i, ea);
                        k[i]++;
                        last_ev = c;
                    end
                end
            end
            for (int i = 0; i < NVECT; i++) exp_b[(NVECT-1-i)*DATA_W +: DATA_W] = bias_m[rb][i];
            check("bias", flow_out_bias, exp_b);
            if (flow_out_valid) begin
                if (first_fv == 0) first_fv = c;
                if (acc < m_len_b) begin
                    idx = (m_start_b + acc * m_incr_b) % BANK_WORDS;
                    for (int i = 0; i < NVECT; i++)
                        exp_w[(NVECT-1-i)*DATA_W +: DATA_W] = bank_m[rb][i][idx];
                    check($sformatf("word%0d", acc), flow_out_weight, exp_w);
                end else begin
                    check("extra_word", 1'b1, 1'b0);
                end
                if (flow_out_ready) begin
                    acc++;
                    last_ev = c;
                end
            end
            @(posedge clk); #1; c++;
        end
        run = 1'b0;
        flow_out_ready = 1'b1;
        if (!done) check("timeout", 1'b0, 1'b1);
        done_cyc = c;
        check("done_time", c, last_ev + 2);
        for (int i = 0; i < NVECT; i++) check($sformatf("fetch_cnt%0d", i), k[i], m_len_a);
        check("stream_cnt", acc, m_len_b);
        check("fv_idle", flow_out_valid, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not reach its summary line");
        $fatal(1);
    end

    initial begin
        n_checks = 0; n_errors = 0; pp_m = 0;
        rst_n = 1'b0; clear = 1'b0; run = 1'b0; valid = 1'b0; wstrb = 1'b0;
        addr = '0; wdata = '0; databus_ready = '0; flow_out_ready = 1'b1;
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < NVECT; i++) bias_m[b][i] = '0;

        #12;
        check("rst_done", done, 1'b1);
        check("rst_dbv", databus_valid, '0);
        check("rst_fv", flow_out_valid, 1'b0);
        check("rst_busy", busy_err, 1'b0);
        check("rst_bias", flow_out_bias, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Run 1: fetch only into bank 0; lane 2 walks 0x1200..0x120C.
        set_cfg(32'h1000, 32'h100, 4, 4, 0, 0, 0, 0);
        do_op(1'b0, 0, 0, 0, dc, ff);
        check("run1_done_cycle", dc, 6);

        // Run 2: stream bank 0 while fetching bank 1; bias is word 0 of run 1.
        set_cfg(32'h2000, 32'h100, 4, 4, 4, 0, 1, 0);
        do_op(1'b0, 0, 0, 0, dc, ff);
        check("run2_first_valid", ff, 2);
        check("run2_done_cycle", dc, 7);
        check("run2_bias", flow_out_bias, 128'hA0001000_A1001100_A2001200_A3001300);

        // Run 3: random databus ready, bias word 3, 3-cycle stall mid-stream.
        set_cfg(32'h3000, 32'h40, 8, 8, 4, 0, 1, 3);
        do_op(1'b1, 3, 3, 0, dc, ff);

        // Run 4: no fetch, strided read wrapping inside bank 0 (5, 3, 1).
        set_cfg(32'h4000, 32'h40, 0, 8, 3, 5, 510, 3);
        do_op(1'b0, 0, 0, 0, dc, ff);
        check("run4_done_cycle", dc, 6);
        check("run4_bias", flow_out_bias, 128'hA0003018_A1003058_A2003098_A30030D8);

        // Run 5: run while active sets busy_err and does not restart.
        set_cfg(32'h5000, 32'h10, 4, 4, 2, 0, 1, 3);
        check("busy_pre", busy_err, 1'b0);
        do_op(1'b0, 0, 0, 2, dc, ff);
        check("busy_set", busy_err, 1'b1);

        // clear wipes busy_err and the config registers.
        clear = 1'b1; @(posedge clk); #1; clear = 1'b0;
        check("busy_clr", busy_err, 1'b0);
        m_ext = 0; m_off = 0; m_len_a = 0; m_incr_a = 0;
        m_len_b = 0; m_start_b = 0; m_incr_b = 0; m_bias_idx = 0;
        do_op(1'b0, 0, 0, 0, dc, ff);
        check("cleared_done_cycle", dc, 2);

        // Reset in the middle of a stalled fetch.
        set_cfg(32'h7000, 32'h10, 8, 4, 0, 0, 0, 0);
        databus_ready = '0;
        run = 1'b1; @(posedge clk); #1; run = 1'b0;
        check("pre_rst_dbv", databus_valid, 4'hF);
        run = 1'b1; @(posedge clk); #1; run = 1'b0;
        check("pre_rst_busy", busy_err, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_dbv", databus_valid, '0);
        check("mid_rst_done", done, 1'b1);
        check("mid_rst_busy", busy_err, 1'b0);
        check("mid_rst_fv", flow_out_valid, 1'b0);
        check("mid_rst_bias", flow_out_bias, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_rst_done", done, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
